// File: rtl/two_port_fifo.sv
// Single-clock first-word-fall-through FIFO over one twoPortMem instance.
// Optional parity protection is enabled with the TWO_PORT_FIFO_PARITY_EN macro.

module twoPortMem #(
   parameter int addresses = 32,
   parameter int width     = 8,
   parameter int muxFactor = 0
) (
   input  logic                         writeClk,
   input  logic                         writeEnable,
   input  logic [$clog2(addresses)-1:0] writeAddress,
   input  logic [width-1:0]             writeData,
   input  logic                         readClk,
   input  logic                         readEnable,
   input  logic [$clog2(addresses)-1:0] readAddress,
   output logic [width-1:0]             readData
);
   logic [width-1:0] r_mem [addresses];

   always_ff @(posedge writeClk)
      if (writeEnable) r_mem[writeAddress] <= writeData;

   // Read data is registered and holds while readEnable is low.
   if (muxFactor >= 0) begin : g_read
      always_ff @(posedge readClk)
         if (readEnable) readData <= r_mem[readAddress];
   end else begin : g_badMux
      assign readData = '0;
   end
endmodule

module two_port_fifo #(
   parameter int addresses        = 32,
   parameter int width            = 8,
   parameter int muxFactor        = 0,
   parameter int almostFullLevel  = 28,
   parameter int almostEmptyLevel = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           writeEnable,
   input  logic [width-1:0]               writeData,
   output logic                           full,
   output logic                           almostFull,
   input  logic                           readEnable,
   output logic [width-1:0]               readData,
   output logic                           empty,
   output logic                           almostEmpty,
   output logic [$clog2(addresses):0]     level,
   output logic                           overflow,
   output logic                           underflow,
   output logic                           parityError
);
   localparam int addressWidth = $clog2(addresses);
`ifdef TWO_PORT_FIFO_PARITY_EN
   localparam int memWidth = width + 1;
`else
   localparam int memWidth = width;
`endif

   logic [addressWidth-1:0] r_wrPtr, r_rdPtr;
   logic [addressWidth:0]   r_level, r_memWords, w_levelNext, w_memWordsNext;
   logic                    r_headValid, r_inFlight;
   logic                    r_full, r_almostFull, r_almostEmpty, r_overflow, r_underflow;
   logic                    w_push, w_pop, w_refill;
   logic [memWidth-1:0]     w_memWrData, w_memRdData;

   assign w_push   = writeEnable && !r_full;
   assign w_pop    = readEnable && r_headValid;
   // While a read is in flight the head slot is already claimed.
   assign w_refill = (r_memWords != '0) && ((!r_headValid && !r_inFlight) || w_pop);

   assign w_levelNext    = r_level + (addressWidth+1)'(w_push) - (addressWidth+1)'(w_pop);
   assign w_memWordsNext = r_memWords + (addressWidth+1)'(w_push) - (addressWidth+1)'(w_refill);

`ifdef TWO_PORT_FIFO_PARITY_EN
   assign w_memWrData = {^writeData, writeData};
`else
   assign w_memWrData = writeData;
`endif

   twoPortMem #(.addresses(addresses), .width(memWidth), .muxFactor(muxFactor)) u_mem (
      .writeClk     (clk),
      .writeEnable  (w_push),
      .writeAddress (r_wrPtr),
      .writeData    (w_memWrData),
      .readClk      (clk),
      .readEnable   (w_refill),
      .readAddress  (r_rdPtr),
      .readData     (w_memRdData)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_level       <= '0;
         r_memWords    <= '0;
         r_headValid   <= 1'b0;
         r_inFlight    <= 1'b0;
         r_full        <= 1'b0;
         r_almostFull  <= 1'b0;
         r_almostEmpty <= 1'b1;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         if (w_push)   r_wrPtr <= r_wrPtr + 1'b1;
         if (w_refill) r_rdPtr <= r_rdPtr + 1'b1;
         r_level    <= w_levelNext;
         r_memWords <= w_memWordsNext;
         r_inFlight <= w_refill && !r_headValid;
         if (r_inFlight)             r_headValid <= 1'b1;
         else if (w_pop && !w_refill) r_headValid <= 1'b0;
         r_full        <= (w_levelNext == (addressWidth+1)'(addresses));
         r_almostFull  <= (w_levelNext >= (addressWidth+1)'(almostFullLevel));
         r_almostEmpty <= (w_levelNext <= (addressWidth+1)'(almostEmptyLevel));
         r_overflow    <= writeEnable && r_full;
         r_underflow   <= readEnable && !r_headValid;
      end
   end

`ifdef TWO_PORT_FIFO_PARITY_EN
   logic r_parityError;
   always_ff @(posedge clk)
      if (reset) r_parityError <= 1'b0;
      else       r_parityError <= w_pop && (^w_memRdData);
   assign parityError = r_parityError;
`else
   assign parityError = 1'b0;
`endif

   assign readData    = w_memRdData[width-1:0];
   assign empty       = !r_headValid;
   assign full        = r_full;
   assign almostFull  = r_almostFull;
   assign almostEmpty = r_almostEmpty;
   assign level       = r_level;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
endmodule

// File: tb/tb_two_port_fifo.sv
// Directed bench for two_port_fifo: vector table plus fill/drain, streaming, reset and parity sequences.

module tb_two_port_fifo;
   logic       clk = 1'b0;
   logic       reset, writeEnable, readEnable;
   logic [7:0] writeData, readData;
   logic       full, almostFull, empty, almostEmpty, overflow, underflow, parityError;
   logic [5:0] level;

   int n_chk = 0;
   int n_fail = 0;

   two_port_fifo dut (
      .clk(clk), .reset(reset), .writeEnable(writeEnable), .writeData(writeData),
      .full(full), .almostFull(almostFull), .readEnable(readEnable), .readData(readData),
      .empty(empty), .almostEmpty(almostEmpty), .level(level), .overflow(overflow),
      .underflow(underflow), .parityError(parityError)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [7:0] wd;
      logic       re;
      logic       e_empty;
      logic       chk_rd;
      logic [7:0] e_rd;
      int         e_level;
      logic       e_ovf;
      logic       e_udf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic we, input logic [7:0] wd, input logic re);
      writeEnable = we;
      writeData   = wd;
      readEnable  = re;
      @(posedge clk);
      #1;
   endtask

   int wcnt, rcnt;

   initial begin
      //            we  wd     re  empty chk  rd     lvl ovf udf
      vecs[0] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};

      reset = 1'b1;
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_aempty", almostEmpty, 1);
      chk("rst_afull", almostFull, 0);
      chk("rst_pulses", {overflow, underflow, parityError}, 0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         tick(vecs[i].we, vecs[i].wd, vecs[i].re);
         chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
         chk($sformatf("v%0d_level", i), level, vecs[i].e_level);
         chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
         chk($sformatf("v%0d_udf", i), underflow, vecs[i].e_udf);
         chk($sformatf("v%0d_perr", i), parityError, 0);
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rd", i), readData, vecs[i].e_rd);
      end

      // fill to full, then overflow
      for (int i = 0; i < 32; i++) begin
         tick(1'b1, 8'(i), 1'b0);
         chk("fill_level", level, i + 1);
         chk("fill_afull", almostFull, (i + 1 >= 28) ? 1 : 0);
         chk("fill_aempty", almostEmpty, (i + 1 <= 4) ? 1 : 0);
         chk("fill_full", full, (i == 31) ? 1 : 0);
      end
      tick(1'b1, 8'hEE, 1'b0);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_level", level, 32);
      tick(1'b0, 8'h00, 1'b0);
      chk("ovf_clear", overflow, 0);

      // drain with readEnable held high: one word per cycle
      for (int i = 0; i < 32; i++) begin
         chk("drain_empty", empty, 0);
         chk("drain_data", readData, i);
         tick(1'b0, 8'h00, 1'b1);
         chk("drain_level", level, 31 - i);
      end
      chk("drain_done", empty, 1);
      chk("drain_full", full, 0);
      tick(1'b0, 8'h00, 1'b1);
      chk("drain_udf", underflow, 1);
      tick(1'b0, 8'h00, 1'b0);
      chk("udf_clear", underflow, 0);

      // streaming push+pop at level 16, across pointer wrap
      wcnt = 0; rcnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, 8'(8'h40 + wcnt), 1'b0);
         wcnt++;
      end
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      chk("strm_start_level", level, 16);
      for (int i = 0; i < 100; i++) begin
         chk("strm_empty", empty, 0);
         chk("strm_data", readData, 8'(8'h40 + rcnt));
         tick(1'b1, 8'(8'h40 + wcnt), 1'b1);
         wcnt++; rcnt++;
         chk("strm_level", level, 16);
      end
      for (int i = 0; i < 6; i++) begin
         chk("pre_rst_data", readData, 8'(8'h40 + rcnt));
         tick(1'b0, 8'h00, 1'b1);
         rcnt++;
      end
      chk("pre_rst_level", level, 10);

      // mid-run reset
      reset = 1'b1;
      tick(1'b0, 8'h00, 1'b0);
      reset = 1'b0;
      chk("mrst_empty", empty, 1);
      chk("mrst_level", level, 0);
      tick(1'b1, 8'hA0, 1'b0);
      tick(1'b1, 8'hA1, 1'b0);
      chk("mrst_inflight_empty", empty, 1);
      chk("mrst_inflight_level", level, 2);
      tick(1'b0, 8'h00, 1'b0);
      chk("mrst_head_empty", empty, 0);
      chk("mrst_head0", readData, 8'hA0);
      tick(1'b0, 8'h00, 1'b1);
      chk("mrst_head1_empty", empty, 0);
      chk("mrst_head1", readData, 8'hA1);
      tick(1'b0, 8'h00, 1'b1);
      chk("mrst_final_empty", empty, 1);
      chk("mrst_final_level", level, 0);

`ifdef TWO_PORT_FIFO_PARITY_EN
      // words land at addresses 2,3,4; corrupt address 3 before it is read
      tick(1'b1, 8'h01, 1'b0);
      tick(1'b1, 8'h02, 1'b0);
      tick(1'b1, 8'h03, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      dut.u_mem.r_mem[3][7] = ~dut.u_mem.r_mem[3][7];
      chk("par_head0", readData, 8'h01);
      tick(1'b0, 8'h00, 1'b1);
      chk("par_ok0", parityError, 0);
      chk("par_head1", readData, 8'h82);
      tick(1'b0, 8'h00, 1'b1);
      chk("par_err1", parityError, 1);
      chk("par_head2", readData, 8'h03);
      tick(1'b0, 8'h00, 1'b1);
      chk("par_ok2", parityError, 0);
`else
      tick(1'b1, 8'h01, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      chk("par_off", parityError, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
